// File: rtl/wb_sdram_traffic_master_if.sv
// Wishbone classic single-beat bus between the traffic master (initiator)
// and the SDRAM controller slave port.
//   cyc, stb, we : cycle / strobe / write-enable (master -> slave)
//   sel          : byte selects (master -> slave)
//   addr         : byte address, AW bits (master -> slave)
//   dat_w        : write data, DW bits (master -> slave)
//   dat_r        : read data, DW bits (slave -> master)
//   ack          : slave acknowledge (slave -> master)
`timescale 1ns/1ps
interface wb_sdram_traffic_master_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          cyc;
   logic          stb;
   logic          we;
   logic [3:0]    sel;
   logic [AW-1:0] addr;
   logic [DW-1:0] dat_w;
   logic [DW-1:0] dat_r;
   logic          ack;

   modport master (output cyc, stb, we, sel, addr, dat_w, input dat_r, ack);
   modport slave  (input cyc, stb, we, sel, addr, dat_w, output dat_r, ack);
endinterface

// File: rtl/wb_sdram_traffic_master.sv
// Wishbone traffic master for SDRAM self-test. After sdr_init_done_i it writes
// NUM_WORDS pattern words (data = SEED ^ {i, ~i}) from START_ADDR upward, reads
// them back and counts mismatches. A missing ack aborts the test with timeout_o.
// Ports:
//   wb_clk_i, wb_rst_i : clock, synchronous active-high reset
//   start_i            : one-cycle start pulse, accepted only in IDLE/DONE
//   sdr_init_done_i    : controller initialisation finished
//   wb                 : Wishbone master modport (cyc/stb/we/sel/addr/dat_w, dat_r/ack)
//   busy_o, done_o     : test running / test finished (sticky)
//   pass_o             : valid with done_o; no mismatch and no timeout
//   err_count_o        : saturating read mismatch count
//   timeout_o          : sticky ack timeout flag
`timescale 1ns/1ps
module wb_sdram_traffic_master #(
   parameter int unsigned     AW         = 32,
   parameter int unsigned     DW         = 32,
   parameter logic [AW-1:0]   START_ADDR = '0,
   parameter int unsigned     NUM_WORDS  = 256,
   parameter logic [DW-1:0]   SEED       = 32'hA5A5_5A5A,
   parameter int unsigned     TIMEOUT    = 1024
) (
   input  logic                        wb_clk_i,
   input  logic                        wb_rst_i,
   input  logic                        start_i,
   input  logic                        sdr_init_done_i,
   wb_sdram_traffic_master_if.master   wb,
   output logic                        busy_o,
   output logic                        done_o,
   output logic                        pass_o,
   output logic [15:0]                 err_count_o,
   output logic                        timeout_o
);

   localparam int unsigned   CW        = $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_LOAD  = CW'(TIMEOUT - 1);
   localparam logic [15:0]   LAST_IDX  = 16'(NUM_WORDS - 1);

   typedef enum logic [2:0] {IDLE, WAIT_INIT, WR, WR_GAP, RD, RD_GAP, DONE} state_t;

   state_t        state, state_n;
   logic [15:0]   idx, idx_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [15:0]   err_n;
   logic          tmo_n;
   logic          cyc_r, we_r, cyc_n, we_n;
   logic [3:0]    sel_r, sel_n;
   logic [AW-1:0] addr_r, addr_n;
   logic [DW-1:0] dat_r, dat_n;
   logic          busy_n, done_n, pass_n;

   function automatic logic [AW-1:0] word_addr(input logic [15:0] i);
      return START_ADDR + AW'({i, 2'b00});
   endfunction

   function automatic logic [DW-1:0] word_data(input logic [15:0] i);
      return SEED ^ DW'({i, ~i});
   endfunction

   always_comb begin
      state_n = state;
      idx_n   = idx;
      cnt_n   = cnt;
      err_n   = err_count_o;
      tmo_n   = timeout_o;
      case (state)
         IDLE, DONE: begin
            if (start_i) state_n = WAIT_INIT;
         end
         WAIT_INIT: begin
            idx_n = '0;
            err_n = '0;
            tmo_n = 1'b0;
            cnt_n = CNT_LOAD;
            if (sdr_init_done_i) state_n = WR;
         end
         WR, RD: begin
            // Ack wins over an expiring counter on the same edge.
            if (wb.ack) begin
               state_n = (state == WR) ? WR_GAP : RD_GAP;
               if (state == RD && wb.dat_r != word_data(idx) && err_count_o != 16'hFFFF)
                  err_n = err_count_o + 16'd1;
            end else if (cnt == '0) begin
               state_n = DONE;
               tmo_n   = 1'b1;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         WR_GAP: begin
            cnt_n = CNT_LOAD;
            if (idx == LAST_IDX) begin
               idx_n   = '0;
               state_n = RD;
            end else begin
               idx_n   = idx + 16'd1;
               state_n = WR;
            end
         end
         RD_GAP: begin
            cnt_n = CNT_LOAD;
            if (idx == LAST_IDX) begin
               state_n = DONE;
            end else begin
               idx_n   = idx + 16'd1;
               state_n = RD;
            end
         end
         default: state_n = IDLE;
      endcase

      // Bus and status outputs are registered from the next state so they
      // line up with the state they describe.
      cyc_n  = (state_n == WR) || (state_n == RD);
      we_n   = (state_n == WR);
      sel_n  = cyc_n ? 4'hF : 4'h0;
      addr_n = cyc_n ? word_addr(idx_n) : '0;
      dat_n  = we_n ? word_data(idx_n) : '0;
      busy_n = (state_n != IDLE) && (state_n != DONE);
      done_n = (state_n == DONE);
      pass_n = done_n && (err_n == '0) && !tmo_n;
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state       <= IDLE;
         cyc_r       <= 1'b0;
         we_r        <= 1'b0;
         sel_r       <= '0;
         addr_r      <= '0;
         dat_r       <= '0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         pass_o      <= 1'b0;
         err_count_o <= '0;
         timeout_o   <= 1'b0;
      end else begin
         state       <= state_n;
         cyc_r       <= cyc_n;
         we_r        <= we_n;
         sel_r       <= sel_n;
         addr_r      <= addr_n;
         dat_r       <= dat_n;
         busy_o      <= busy_n;
         done_o      <= done_n;
         pass_o      <= pass_n;
         err_count_o <= err_n;
         timeout_o   <= tmo_n;
      end
   end

   // Word index and ack counter are always reloaded before use.
   always_ff @(posedge wb_clk_i) begin
      idx <= idx_n;
      cnt <= cnt_n;
   end

   assign wb.cyc   = cyc_r;
   assign wb.stb   = cyc_r;
   assign wb.we    = we_r;
   assign wb.sel   = sel_r;
   assign wb.addr  = addr_r;
   assign wb.dat_w = dat_r;

endmodule

// File: tb/tb_wb_sdram_traffic_master.sv
`timescale 1ns/1ps
module tb_wb_sdram_traffic_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        init_done;
   logic        busy, done, pass, tmo;
   logic [15:0] err;

   wb_sdram_traffic_master_if #(.AW(32), .DW(32)) wb();

   wb_sdram_traffic_master #(
      .AW(32), .DW(32), .START_ADDR(32'h0), .NUM_WORDS(4),
      .SEED(32'hA5A5_5A5A), .TIMEOUT(16)
   ) dut (
      .wb_clk_i        (clk),
      .wb_rst_i        (rst),
      .start_i         (start),
      .sdr_init_done_i (init_done),
      .wb              (wb.master),
      .busy_o          (busy),
      .done_o          (done),
      .pass_o          (pass),
      .err_count_o     (err),
      .timeout_o       (tmo)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Slave model: zero-wait ack (k=1), 4-word memory, optional bit0 corruption.
   logic        ack_en    = 1'b0;
   logic        stray_ack = 1'b0;
   int          corrupt_idx = -1;
   logic [31:0] mem [0:3];
   logic [31:0] exp_data [0:3];

   always_comb begin
      wb.ack   = stray_ack | (ack_en & wb.cyc & wb.stb);
      wb.dat_r = '0;
      if (wb.cyc && !wb.we) begin
         wb.dat_r = mem[wb.addr[3:2]];
         if (int'(wb.addr[3:2]) == corrupt_idx) wb.dat_r[0] = ~wb.dat_r[0];
      end
   end

   // Transaction log and bus-rule monitor, sampled mid-cycle.
   int          tx_n = 0;
   logic        tx_we   [0:63];
   logic [31:0] tx_addr [0:63];
   logic [31:0] tx_dat  [0:63];
   int          viol = 0;
   logic        rst_seen = 1'b0;

   always @(posedge clk) rst_seen <= rst;

   always @(negedge clk) begin
      if ((wb.stb && !wb.cyc) || (wb.cyc && wb.sel != 4'hF) || (!wb.cyc && wb.sel != 4'h0) ||
          (!wb.cyc && (wb.we || wb.dat_w != 32'h0)) || (rst_seen && (wb.cyc || wb.stb)))
         viol <= viol + 1;
      if (wb.cyc && wb.stb && wb.ack && tx_n < 64) begin
         tx_we[tx_n]   <= wb.we;
         tx_addr[tx_n] <= wb.addr;
         tx_dat[tx_n]  <= wb.we ? wb.dat_w : wb.dat_r;
         tx_n          <= tx_n + 1;
         if (wb.we) mem[wb.addr[3:2]] <= wb.dat_w;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic pulse_start;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_cyc(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (wb.cyc) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      bit ok;
      rst = 1'b1; start = 1'b0; init_done = 1'b0; ack_en = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({wb.cyc, wb.stb, wb.we, wb.sel, busy, done, pass, tmo, err} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: cyc=%b stb=%b busy=%b done=%b err=%h, required all 0",
                  wb.cyc, wb.stb, busy, done, err);
      end
      rst = 1'b0; init_done = 1'b1;
      pulse_start();
      wait_cyc(ok);
      checks++;
      if (!ok || wb.stb !== 1'b1) begin
         failures++;
         $display("FAIL reset_prestb: stb=%b, required 1", wb.stb);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({wb.cyc, wb.stb, busy, done} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_midcycle: cyc=%b stb=%b busy=%b done=%b, required 0000",
                  wb.cyc, wb.stb, busy, done);
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if ({wb.cyc, busy, done} !== 3'b000) begin
         failures++;
         $display("FAIL reset_idle: cyc=%b busy=%b done=%b, required 000", wb.cyc, busy, done);
      end
   endtask

   task automatic test_init_gating;
      int n_cyc = 0;
      init_done = 1'b0; ack_en = 1'b0;
      pulse_start();
      repeat (500) begin
         @(negedge clk);
         if (wb.cyc) n_cyc++;
      end
      checks++;
      if (n_cyc != 0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL gating_wait: cyc_cycles=%0d busy=%b, required 0 and 1", n_cyc, busy);
      end
      init_done = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({wb.cyc, wb.stb, wb.we} !== 3'b111 || wb.sel !== 4'hF) begin
         failures++;
         $display("FAIL gating_first_ctl: cyc=%b stb=%b we=%b sel=%h, required 111 F",
                  wb.cyc, wb.stb, wb.we, wb.sel);
      end
      checks++;
      if (wb.addr !== 32'h0 || wb.dat_w !== 32'hA5A5_A5A5) begin
         failures++;
         $display("FAIL gating_first_word: addr=%h dat=%h, required 00000000 a5a5a5a5",
                  wb.addr, wb.dat_w);
      end
      repeat (30) @(negedge clk);
   endtask

   task automatic test_clean_run;
      bit ok;
      int n = 0;
      int base;
      ack_en = 1'b1; corrupt_idx = -1;
      base = tx_n;
      pulse_start();
      wait_cyc(ok);
      while (ok && !done && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!ok || n != 16) begin
         failures++;
         $display("FAIL clean_duration: cycles=%0d started=%b, required 16", n, ok);
      end
      checks++;
      if ({done, pass, tmo, busy} !== 4'b1100 || err !== 16'h0) begin
         failures++;
         $display("FAIL clean_status: done=%b pass=%b timeout=%b busy=%b err=%0d, required 1100 err 0",
                  done, pass, tmo, busy, err);
      end
      checks++;
      if (tx_n - base != 8) begin
         failures++;
         $display("FAIL clean_tx_count: got %0d, required 8", tx_n - base);
      end else begin
         for (int k = 0; k < 8; k++) begin
            checks++;
            if (tx_we[base+k] !== (k < 4) || tx_addr[base+k] !== 32'(4 * (k % 4)) ||
                tx_dat[base+k] !== exp_data[k % 4]) begin
               failures++;
               $display("FAIL clean_tx%0d: we=%b addr=%h dat=%h, required we=%b addr=%h dat=%h",
                        k, tx_we[base+k], tx_addr[base+k], tx_dat[base+k],
                        (k < 4), 32'(4 * (k % 4)), exp_data[k % 4]);
            end
         end
      end
   endtask

   task automatic test_corruption;
      int n = 0;
      ack_en = 1'b1; corrupt_idx = 2;
      pulse_start();
      while (done && n < 5) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      while (!done && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (err !== 16'd1 || {done, pass, tmo} !== 3'b100) begin
         failures++;
         $display("FAIL corrupt_status: err=%0d done=%b pass=%b timeout=%b, required 1 100",
                  err, done, pass, tmo);
      end
      corrupt_idx = -1;
   endtask

   task automatic test_timeout;
      bit ok;
      int n = 0;
      ack_en = 1'b0;
      pulse_start();
      wait_cyc(ok);
      while (ok && wb.cyc && n < 200) begin
         n++;
         @(negedge clk);
      end
      checks++;
      if (!ok || n != 16) begin
         failures++;
         $display("FAIL timeout_cycles: stb_cycles=%0d, required 16", n);
      end
      repeat (2) @(negedge clk);
      checks++;
      if ({tmo, done, pass, busy} !== 4'b1100) begin
         failures++;
         $display("FAIL timeout_status: timeout=%b done=%b pass=%b busy=%b, required 1100",
                  tmo, done, pass, busy);
      end
   endtask

   task automatic test_protocol;
      bit ok;
      int n = 0;
      int base;
      ack_en = 1'b1;
      base = tx_n;
      pulse_start();
      wait_cyc(ok);
      while (ok && !done && n < 200) begin
         @(negedge clk);
         n++;
         if (n == 1) stray_ack = 1'b1;
         else if (n == 2) begin
            stray_ack = 1'b0;
            start = 1'b1;
         end else if (n == 3) start = 1'b0;
      end
      stray_ack = 1'b0; start = 1'b0;
      checks++;
      if (!ok || n != 16) begin
         failures++;
         $display("FAIL protocol_duration: cycles=%0d, required 16", n);
      end
      checks++;
      if ({done, pass, tmo} !== 3'b110 || err !== 16'h0) begin
         failures++;
         $display("FAIL protocol_status: done=%b pass=%b timeout=%b err=%0d, required 110 0",
                  done, pass, tmo, err);
      end
      checks++;
      if (tx_n - base != 8 || tx_addr[base+1] !== 32'h4 || tx_we[base+1] !== 1'b1 ||
          tx_addr[base+4] !== 32'h0 || tx_we[base+4] !== 1'b0) begin
         failures++;
         $display("FAIL protocol_sequence: count=%0d addr1=%h addr4=%h, required 8 00000004 00000000",
                  tx_n - base, tx_addr[base+1], tx_addr[base+4]);
      end
      repeat (10) @(negedge clk);
      checks++;
      if ({done, busy, wb.cyc} !== 3'b100) begin
         failures++;
         $display("FAIL protocol_no_restart: done=%b busy=%b cyc=%b, required 100", done, busy, wb.cyc);
      end
      checks++;
      if (viol != 0) begin
         failures++;
         $display("FAIL bus_rules: violations=%0d, required 0", viol);
      end
   endtask

   initial begin
      exp_data[0] = 32'hA5A5_A5A5;
      exp_data[1] = 32'hA5A4_A5A4;
      exp_data[2] = 32'hA5A7_A5A7;
      exp_data[3] = 32'hA5A6_A5A6;
      rst = 1'b1; start = 1'b0; init_done = 1'b0;
      @(negedge clk);
      test_reset();
      test_init_gating();
      test_clean_run();
      test_corruption();
      test_timeout();
      test_protocol();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
